// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter.
// Optional feature macro: WB_HAZARD_EN (pending-write query port).
package wb_arbiter_pkg;
  localparam int REG_ADR_W = 5;

  typedef struct packed {
    logic [REG_ADR_W-1:0] rd;
    logic [31:0]          data;
  } wb_entry_t;

  // Round-robin winner: first set bit of req scanning up from ptr with wrap.
  // Scanning downward lets the lowest offset overwrite the result last.
  function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
    int win;
    win = 0;
    for (int k = n - 1; k >= 0; k--)
      if (req[5'((ptr + k) % n)]) win = (ptr + k) % n;
    return win;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Result-channel and writeback bus between execution units, arbiter and register file.
// Optional feature macro: WB_HAZARD_EN adds query_adr/query_hit.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NCH  = 2
);
  logic                                flush;
  logic [NCH-1:0]                      in_v;
  logic [NCH-1:0]                      in_ok;
  logic [NCH-1:0][REG_ADR_W-1:0]       in_rd;
  logic [NCH-1:0][XLEN-1:0]            in_data;
  logic                                res_v;
  logic [REG_ADR_W-1:0]                res_adr;
  logic [XLEN-1:0]                     res_data;
  logic                                res_ok;
`ifdef WB_HAZARD_EN
  logic [REG_ADR_W-1:0]                query_adr;
  logic                                query_hit;
`endif

  modport slave (
    input  flush, in_v, in_rd, in_data, res_ok,
    output in_ok, res_v, res_adr, res_data
`ifdef WB_HAZARD_EN
    , input query_adr, output query_hit
`endif
  );

  modport master (
    output flush, in_v, in_rd, in_data, res_ok,
    input  in_ok, res_v, res_adr, res_data
`ifdef WB_HAZARD_EN
    , output query_adr, input query_hit
`endif
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// Per-channel result FIFO; no pass-through when full.
// Optional feature macro: WB_HAZARD_EN exports entry contents and valid flags.
module wb_arbiter_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
`ifdef WB_HAZARD_EN
  , output logic [DEPTH-1:0]   ent_v
  , output entry_t [DEPTH-1:0] ent
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   cnt;
  logic [AW-1:0] wp, rp;
  entry_t        mem [DEPTH];

  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head  = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      wp  <= '0;
      rp  <= '0;
    end else if (flush) begin
      cnt <= '0;
      wp  <= '0;
      rp  <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

`ifdef WB_HAZARD_EN
  // Slot j is live when its distance from the read pointer is below the count.
  for (genvar j = 0; j < DEPTH; j++) begin : g_ent
    logic [AW-1:0] off;
    assign off      = AW'(j) - rp;
    assign ent_v[j] = {1'b0, off} < cnt;
    assign ent[j]   = mem[j];
  end
`endif
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NCH buffered result streams, round-robin into one registered write port.
// Optional feature macro: WB_HAZARD_EN adds a combinational pending-write query.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);
  localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef struct packed {
    logic [REG_ADR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } entry_t;

  logic [NCH-1:0]   push, pop, full, empty;
  entry_t [NCH-1:0] head;
  logic [RW-1:0]    rr, pick;
  logic             load, any;

  assign bus.in_ok = ~full;
  assign load      = !bus.res_v || bus.res_ok;
  assign any       = |(~empty);
  assign pick      = RW'(rr_pick(32'(~empty), int'(rr), NCH));

`ifdef WB_HAZARD_EN
  logic [NCH-1:0][DEPTH-1:0] hit;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // x0 results complete the handshake but are never stored.
    assign push[i] = bus.in_v[i] && !full[i] && (bus.in_rd[i] != '0) && !bus.flush;
    assign pop[i]  = load && any && (pick == RW'(i)) && !bus.flush;

`ifdef WB_HAZARD_EN
    logic [DEPTH-1:0]   ent_v;
    entry_t [DEPTH-1:0] ent;
    for (genvar j = 0; j < DEPTH; j++) begin : g_hit
      assign hit[i][j] = ent_v[j] && (ent[j].rd == bus.query_adr);
    end
`endif

    wb_arbiter_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({bus.in_rd[i], bus.in_data[i]}),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
`ifdef WB_HAZARD_EN
      , .ent_v (ent_v)
      , .ent   (ent)
`endif
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_v    <= 1'b0;
      bus.res_adr  <= '0;
      bus.res_data <= '0;
      rr           <= '0;
    end else if (bus.flush) begin
      bus.res_v <= 1'b0;
    end else if (load) begin
      bus.res_v <= any;
      if (any) begin
        bus.res_adr  <= head[pick].rd;
        bus.res_data <= head[pick].data;
        rr           <= RW'((int'(pick) + 1) % NCH);
      end
    end
  end

`ifdef WB_HAZARD_EN
  assign bus.query_hit = (bus.query_adr != '0) &&
                         ((|hit) || (bus.res_v && (bus.res_adr == bus.query_adr)));
`endif
endmodule
